// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: grants one requester at a time a burst of up to
// BURST_MAX words into a FIFO write port, stalling cleanly on wfull.
module fifo_wr_arb #(
    parameter int DSIZE     = 8,
    parameter int NREQ      = 4,
    parameter int BURST_MAX = 4
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*DSIZE-1:0] req_wdata,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [15:0]           stall_cnt
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                        state;
    logic [IW-1:0]                 gidx;
    logic [IW-1:0]                 prev;
    logic [BW-1:0]                 beat;
    logic [IW-1:0]                 pick;
    logic                          pick_vld;
    logic [NREQ-1:0][DSIZE-1:0]    words;
    logic                          gval;
    logic                          glast;
    logic                          xfer;

    assign words = req_wdata;
    assign gval  = req_valid[gidx];
    assign glast = req_last[gidx];

    // Reset gating keeps the reset cycle free of transfers even mid-burst.
    assign xfer      = (state == BUSY) && gval && !wfull && !wrst;
    assign winc      = xfer;
    assign req_ready = xfer ? gnt : '0;
    assign wdata     = xfer ? words[gidx] : '0;

    // Scan downward so the candidate closest to prev+1 is the one left standing.
    always_comb begin
        int c;
        c        = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            c = (int'(prev) + k) % NREQ;
            if (req_valid[IW'(c)]) begin
                pick     = IW'(c);
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state     <= IDLE;
            gnt       <= '0;
            gidx      <= '0;
            beat      <= '0;
            prev      <= IW'(NREQ - 1);
            stall_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state     <= BUSY;
                        gidx      <= pick;
                        gnt       <= '0;
                        gnt[pick] <= 1'b1;
                        beat      <= '0;
                    end
                end
                BUSY: begin
                    if (!gval) begin
                        state <= IDLE;
                        gnt   <= '0;
                        prev  <= gidx;
                    end else if (wfull) begin
                        if (stall_cnt != 16'hFFFF)
                            stall_cnt <= stall_cnt + 16'd1;
                    end else begin
                        beat <= beat + BW'(1);
                        if (glast || (beat == BW'(BURST_MAX - 1))) begin
                            state <= IDLE;
                            gnt   <= '0;
                            prev  <= gidx;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios plus random traffic, every cycle
// compared against a burst-level reference model.
module tb_fifo_wr_arb;

    localparam int DSIZE     = 8;
    localparam int NREQ      = 4;
    localparam int BURST_MAX = 4;

    logic                       wclk = 1'b0;
    logic                       wrst = 1'b1;
    logic [NREQ-1:0]            req_valid = '0;
    logic [NREQ-1:0]            req_last  = '0;
    logic [NREQ-1:0][DSIZE-1:0] wd = '0;
    logic [NREQ-1:0]            req_ready;
    logic                       wfull = 1'b0;
    logic                       winc;
    logic [DSIZE-1:0]           wdata;
    logic [NREQ-1:0]            gnt;
    logic [15:0]                stall_cnt;

    fifo_wr_arb #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST_MAX(BURST_MAX)) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_wdata (wd),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .gnt       (gnt),
        .stall_cnt (stall_cnt)
    );

    always #5 wclk = ~wclk;

    int ncmp  = 0;
    int nfail = 0;

    // Reference model: who owns the port (-1 = nobody), beats done, last owner.
    int owner  = -1;
    int lastg  = NREQ - 1;
    int beats  = 0;
    int mstall = 0;

    logic             seen_winc;
    logic [NREQ-1:0]  seen_ready;
    logic [NREQ-1:0]  seen_gnt;
    logic [DSIZE-1:0] seen_wdata;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        assert (act === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic mdl_edge();
        if (wrst) begin
            owner = -1; lastg = NREQ - 1; beats = 0; mstall = 0;
        end else if (owner < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (owner < 0 && req_valid[(lastg + k) % NREQ]) begin
                    owner = (lastg + k) % NREQ;
                    beats = 0;
                end
            end
        end else if (!req_valid[owner]) begin
            lastg = owner; owner = -1;
        end else if (wfull) begin
            if (mstall < 65535) mstall++;
        end else begin
            beats++;
            if (req_last[owner] || beats == BURST_MAX) begin
                lastg = owner; owner = -1;
            end
        end
    endtask

    task automatic tick();
        logic            xe;
        logic [NREQ-1:0] ge;
        @(negedge wclk);
        xe = (owner >= 0) && req_valid[owner] && !wfull && !wrst;
        ge = (owner >= 0) ? NREQ'(1) << owner : '0;
        chk("winc",  winc, xe);
        chk("ready", req_ready, xe ? ge : '0);
        chk("wdata", wdata, xe ? wd[owner] : '0);
        chk("gnt",   gnt, ge);
        chk("stall", stall_cnt, mstall);
        seen_winc  = winc;
        seen_ready = req_ready;
        seen_gnt   = gnt;
        seen_wdata = wdata;
        @(posedge wclk);
        mdl_edge();
        #1;
    endtask

    task automatic do_reset();
        wrst = 1'b1; req_valid = '0; req_last = '0; wfull = 1'b0;
        @(posedge wclk);
        mdl_edge();
        #1;
        tick();
        wrst = 1'b0;
    endtask

    initial begin
        int n, st, wcnt;
        logic [31:0]      wlog;
        logic [NREQ-1:0]  glog [16];
        logic [DSIZE-1:0] got  [8];

        // Reset state and first cycle after reset.
        do_reset();
        chk("rst_gnt", seen_gnt, 0);
        chk("rst_winc", seen_winc, 0);
        chk("rst_wdata", seen_wdata, 0);
        tick();
        chk("post_rst_winc", seen_winc, 0);
        chk("post_rst_stall", stall_cnt, 0);

        // Two requesters held valid: 0, then 2, then 0 again.
        do_reset();
        req_valid = 4'b0101;
        for (int c = 0; c < 12; c++) begin tick(); glog[c] = seen_gnt; end
        chk("rr_first", glog[1], 4'b0001);
        chk("rr_gap", glog[5], 4'b0000);
        chk("rr_second", glog[6], 4'b0100);
        chk("rr_third", glog[11], 4'b0001);

        // Six-word stream split by BURST_MAX with one arbitration gap.
        do_reset();
        req_valid = 4'b0100; n = 0; wlog = '0;
        for (int c = 0; c < 30 && n < 6; c++) begin
            wd[2]    = 8'(8'hA0 + n);
            req_last = (n == 5) ? 4'b0100 : 4'b0000;
            tick();
            wlog[c] = seen_winc;
            if (seen_winc) begin got[n] = seen_wdata; n++; end
        end
        req_valid = '0; req_last = '0;
        chk("burst_cnt", n, 6);
        chk("burst_pat", wlog[7:0], 8'b11011110);
        for (int k = 0; k < 6; k++) chk("burst_data", got[k], 8'(8'hA0 + k));

        // Three-cycle wfull stall in mid-burst.
        do_reset();
        req_valid = 4'b0010; n = 0; st = 0;
        for (int c = 0; c < 30 && n < 4; c++) begin
            wd[1]    = 8'(8'hB0 + n);
            req_last = (n == 3) ? 4'b0010 : 4'b0000;
            wfull    = (n == 2 && st < 3);
            tick();
            if (wfull) st++;
            if (seen_winc) begin got[n] = seen_wdata; n++; end
        end
        wfull = 1'b0; req_valid = '0; req_last = '0;
        chk("stall_words", n, 4);
        chk("stall_cnt3", stall_cnt, 3);
        for (int k = 0; k < 4; k++) chk("stall_data", got[k], 8'(8'hB0 + k));

        // Granted requester withdraws after two beats.
        do_reset();
        req_valid = 4'b1011; n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            wd = {NREQ{8'(c)}};
            tick();
            if (seen_ready[0]) n++;
        end
        chk("drop_beats", n, 2);
        req_valid = 4'b1010;
        tick();
        chk("drop_noxfer", seen_winc, 0);
        tick();
        chk("drop_idle", seen_gnt, 0);
        tick();
        chk("drop_next", seen_gnt, 4'b0010);
        req_valid = '0;
        tick();

        // Reset in the middle of a burst.
        do_reset();
        req_valid = 4'b0110;
        tick(); tick();
        chk("mid_busy", seen_gnt, 4'b0010);
        wrst = 1'b1;
        tick();
        chk("mid_rst_winc", seen_winc, 0);
        wrst = 1'b0;
        tick();
        chk("mid_after_gnt", seen_gnt, 0);
        chk("mid_after_winc", seen_winc, 0);
        tick();
        chk("mid_regrant", seen_gnt, 4'b0010);
        req_valid = '0;
        tick(); tick();

        // Long stall saturates the counter.
        do_reset();
        req_valid = 4'b0001; wfull = 1'b1; wcnt = 0;
        repeat (70000) begin
            tick();
            if (seen_winc) wcnt++;
        end
        chk("sat_stall", stall_cnt, 16'hFFFF);
        chk("sat_nowinc", wcnt, 0);
        wfull = 1'b0; req_valid = '0;

        // Random traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            req_valid = NREQ'($urandom);
            req_last  = NREQ'($urandom & $urandom);
            for (int i = 0; i < NREQ; i++) wd[i] = DSIZE'($urandom);
            wfull = ($urandom_range(3) == 0);
            wrst  = ($urandom_range(127) == 0);
            tick();
        end
        wrst = 1'b0; req_valid = '0; wfull = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
